// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per ADD3/SHIFT pair.
// Result is latched on the final shift and held until the next completion.
module bin_to_bcd #(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned SW = 4 * DIGITS + BIN_W;
    localparam int unsigned CW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {StIdle, StAdd3, StShift, StDone} state_e;

    state_e              state_q, state_d;
    logic [SW-1:0]       s_q, s_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [SW-1:0]       s_add;
    logic [SW-1:0]       s_shl;

    always_comb begin
        s_add = s_q;
        // Nibbles never exceed 9, so +3 on a nibble >= 5 stays inside that nibble.
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (s_q[BIN_W + 4*i +: 4] >= 4'd5) begin
                s_add[BIN_W + 4*i +: 4] = s_q[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        s_shl = {s_q[SW-2:0], 1'b0};
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    s_d     = {{(4*DIGITS){1'b0}}, bin};
                    cnt_d   = CW'(BIN_W);
                    state_d = StAdd3;
                end
            end
            StAdd3: begin
                s_d     = s_add;
                state_d = StShift;
            end
            StShift: begin
                s_d   = s_shl;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = s_shl[SW-1:BIN_W];
                    state_d = StDone;
                end else begin
                    state_d = StAdd3;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            s_q     <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed self-checking bench for bin_to_bcd: vector table, sweep against a decimal model,
// and hand-written sequences for ignored start, mid-conversion reset and back-to-back starts.
module tb_bin_to_bcd;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [19:0] bcd;

    int total;
    int bad;

    bin_to_bcd #(.BIN_W(16), .DIGITS(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] b;
        logic [19:0] exp;
    } vec_t;

    function automatic logic [19:0] bcd_model(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one conversion; mode 1 also fires a second start at cycle 10 and scrambles bin.
    task automatic run_conv(input logic [15:0] b, input int mode, output logic [19:0] res,
                            output int lat, output int ndone, output int nbusy);
        int i;
        @(negedge clk);
        bin   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        ndone = 0;
        nbusy = 0;
        i     = 0;
        while (i <= 40) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (lat < 0) lat = i;
            end
            if (mode == 1) begin
                bin   = 16'($urandom);
                start = (i == 10);
            end
            if (!busy) break;
            i++;
        end
        start = 1'b0;
        res   = bcd;
    endtask

    vec_t        vecs[12];
    logic [19:0] res;
    int          lat;
    int          ndone;
    int          nbusy;
    int          sweep_bad;
    int          last_done;
    int          gap_idle;
    int          conv_seen;
    logic [3:0]  nib;

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = '{16'd0,     20'h00000};
        vecs[1]  = '{16'h3039,  20'h12345};
        vecs[2]  = '{16'd65535, 20'h65535};
        vecs[3]  = '{16'd10000, 20'h10000};
        vecs[4]  = '{16'd59999, 20'h59999};
        vecs[5]  = '{16'd65534, 20'h65534};
        vecs[6]  = '{16'd9,     20'h00009};
        vecs[7]  = '{16'd10,    20'h00010};
        vecs[8]  = '{16'd99,    20'h00099};
        vecs[9]  = '{16'd4999,  20'h04999};
        vecs[10] = '{16'd5000,  20'h05000};
        vecs[11] = '{16'd9999,  20'h09999};

        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 12; v++) begin
            run_conv(vecs[v].b, 0, res, lat, ndone, nbusy);
            check($sformatf("vec%0d_bcd", v), 32'(res), 32'(vecs[v].exp));
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'd32);
            check($sformatf("vec%0d_ndone", v), 32'(ndone), 32'd1);
            check($sformatf("vec%0d_busy_cycles", v), 32'(nbusy), 32'd33);
        end

        // Reduced sweep: all of 0..99, then every 97th value up to 9999.
        sweep_bad = 0;
        for (int unsigned x = 0; x <= 9999; x = (x < 99) ? x + 1 : x + 97) begin
            run_conv(16'(x), 0, res, lat, ndone, nbusy);
            for (int d = 0; d < 5; d++) begin
                nib = res[4*d +: 4];
                if (nib > 4'd9) sweep_bad++;
            end
            if (res !== bcd_model(x) || ndone != 1) begin
                sweep_bad++;
                if (sweep_bad < 5)
                    $display("FAIL sweep_%0d: got 0x%0h expected 0x%0h", x, res, bcd_model(x));
            end
        end
        check("sweep_errors", 32'(sweep_bad), 32'd0);

        // Second start and bin changes during busy are ignored.
        run_conv(16'd100, 1, res, lat, ndone, nbusy);
        check("ignore_bcd", 32'(res), 32'h00100);
        check("ignore_ndone", 32'(ndone), 32'd1);
        check("ignore_latency", 32'(lat), 32'd32);
        repeat (2) @(negedge clk);
        check("ignore_no_requeue", 32'(busy), 32'd0);

        // Mid-conversion reset: bcd currently holds 0x00100, so bcd=0 proves it was cleared.
        @(negedge clk);
        bin   = 16'd4321;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i <= 50; i++) begin
            @(negedge clk);
            if (i == 15) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_bcd", 32'(bcd), 32'd0);
                check("rst_done", 32'(done), 32'd0);
            end
            if (i == 17) rst_n = 1'b1;
            if (done) ndone++;
        end
        check("rst_no_done", 32'(ndone), 32'd0);
        run_conv(16'd7, 0, res, lat, ndone, nbusy);
        check("post_rst_bcd", 32'(res), 32'h00007);
        check("post_rst_latency", 32'(lat), 32'd32);

        // start held high: one conversion every 34 cycles, one idle cycle between.
        @(negedge clk);
        bin       = 16'd42;
        start     = 1'b1;
        last_done = -1;
        gap_idle  = 0;
        conv_seen = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (!busy) gap_idle++;
            if (done) begin
                conv_seen++;
                check($sformatf("held_bcd_%0d", conv_seen), 32'(bcd), 32'h00042);
                if (last_done >= 0) begin
                    check($sformatf("held_period_%0d", conv_seen), 32'(i - last_done), 32'd34);
                    check($sformatf("held_idle_%0d", conv_seen), 32'(gap_idle), 32'd1);
                end
                last_done = i;
                gap_idle  = 0;
            end
        end
        check("held_conversions", 32'(conv_seen >= 4), 32'd1);
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
